// File: rtl/uart_periph_fifo.sv
// uart_periph_fifo: memory-mapped UART with TX/RX FIFOs, programmable 16x baud tick,
// optional parity, sticky error flags and a level interrupt.
module uart_periph_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 650
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [1:0]  addr_i,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic [5:0] ctrl_q;
    logic [15:0] div_q, tick_cnt_q;
    logic tick, wr_ctrl, wr_data, wr_div, rd_data, clr;
    logic ovr_q, ferr_q, perr_q, irq_q, tx_q, tx_d;
    logic rx_s1_q, rx_s2_q, rx_s3_q;
    state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_head, rx_head;
    logic tx_par_q, tx_par_d, rx_pok_q, rx_pok_d;
    logic tx_bend, tx_start_ok, tx_pop, tx_push, tx_full, tx_empty;
    logic rx_samp, rx_fall, rx_good, rx_ferr, rx_perr, rx_pop, rx_push, rx_full, rx_empty;
    logic [DATA_BITS-1:0] txm_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rxm_q [FIFO_DEPTH];
    logic [AW-1:0] txw_q, txr_q, rxw_q, rxr_q;
    logic [CW-1:0] txc_q, rxc_q;
    logic unused_wdata;

    assign unused_wdata = ^wdata_i[31:16];
    assign wr_ctrl = wr_i && addr_i == 2'd0;
    assign wr_data = wr_i && addr_i == 2'd1;
    assign wr_div  = wr_i && addr_i == 2'd2;
    assign rd_data = rd_i && addr_i == 2'd1;
    assign clr     = wr_ctrl && wdata_i[8];
    assign tick    = tick_cnt_q == div_q;

    assign tx_empty = txc_q == '0;
    assign tx_full  = txc_q == CW'(FIFO_DEPTH);
    assign rx_empty = rxc_q == '0;
    assign rx_full  = rxc_q == CW'(FIFO_DEPTH);
    assign tx_head  = txm_q[txr_q];
    assign rx_head  = rx_empty ? '0 : rxm_q[rxr_q];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign tx_push  = wr_data && (!tx_full || tx_pop);
    assign rx_pop   = rd_data && !rx_empty;
    assign rx_push  = rx_good && (!rx_full || rx_pop);

    assign tx_start_ok = ctrl_q[0] && !tx_empty;
    assign tx_bend     = tick && tx_tcnt_q == 4'd15;
    assign rx_fall     = rx_s3_q && !rx_s2_q;
    assign rx_samp     = tick && rx_tcnt_q == 4'd7;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = (tx_state_q != IDLE && tick) ? tx_tcnt_q + 4'd1 : tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE:    tx_pop = tick && tx_start_ok;
            START:   if (tx_bend) begin
                tx_state_d = DATA;
                tx_bit_d   = 3'd0;
            end
            DATA:    if (tx_bend) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = ctrl_q[2] ? PARITY : STOP;
            end
            PARITY:  if (tx_bend) tx_state_d = STOP;
            STOP:    if (tx_bend) begin
                tx_state_d = IDLE;
                tx_pop     = tx_start_ok;
            end
            default: tx_state_d = IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = START;
            tx_tcnt_d  = 4'd0;
            tx_sh_d    = tx_head;
            tx_par_d   = ^tx_head ^ ctrl_q[3];
        end
        tx_d = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_sh_d[0] :
               tx_state_d == PARITY ? tx_par_d : 1'b1;
    end

    // The bit-tick counter free-runs mod 16 from the start edge, so every sample lands on tick 8.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = (rx_state_q != IDLE && tick) ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_pok_d   = rx_pok_q;
        rx_good    = 1'b0;
        rx_ferr    = 1'b0;
        rx_perr    = 1'b0;
        case (rx_state_q)
            IDLE:    if (ctrl_q[1] && rx_fall) begin
                rx_state_d = START;
                rx_tcnt_d  = 4'd0;
            end
            START:   if (rx_samp) begin
                rx_state_d = rx_s2_q ? IDLE : DATA;
                rx_bit_d   = 3'd0;
                rx_pok_d   = 1'b1;
            end
            DATA:    if (rx_samp) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = ctrl_q[2] ? PARITY : STOP;
            end
            PARITY:  if (rx_samp) begin
                rx_pok_d   = rx_s2_q == (^rx_sh_q ^ ctrl_q[3]);
                rx_state_d = STOP;
            end
            STOP:    if (rx_samp) begin
                rx_state_d = IDLE;
                rx_ferr    = !rx_s2_q;
                rx_perr    = rx_s2_q && !rx_pok_q;
                rx_good    = rx_s2_q && rx_pok_q;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) txm_q[txw_q] <= wdata_i[DATA_BITS-1:0];
        if (rx_push) rxm_q[rxw_q] <= rx_sh_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ctrl_q     <= '0;
            div_q      <= 16'(DIV_RESET);
            tick_cnt_q <= '0;
            {ovr_q, ferr_q, perr_q, irq_q} <= '0;
            tx_q       <= 1'b1;
            {rx_s1_q, rx_s2_q, rx_s3_q} <= '1;
            tx_state_q <= IDLE;
            rx_state_q <= IDLE;
            {tx_tcnt_q, rx_tcnt_q, tx_bit_q, rx_bit_q} <= '0;
            {tx_sh_q, rx_sh_q, tx_par_q, rx_pok_q} <= '0;
            {txw_q, txr_q, rxw_q, rxr_q, txc_q, rxc_q} <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= wdata_i[5:0];
            if (wr_div) div_q <= wdata_i[15:0];
            tick_cnt_q <= (wr_div || tick) ? '0 : tick_cnt_q + 16'd1;
            ovr_q      <= (rx_good && rx_full && !rx_pop) || (ovr_q && !clr);
            ferr_q     <= rx_ferr || (ferr_q && !clr);
            perr_q     <= rx_perr || (perr_q && !clr);
            irq_q      <= (ctrl_q[4] && !rx_empty) || (ctrl_q[5] && tx_empty);
            tx_q       <= tx_d;
            {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx_i, rx_s1_q, rx_s2_q};
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            {tx_tcnt_q, rx_tcnt_q, tx_bit_q, rx_bit_q} <= {tx_tcnt_d, rx_tcnt_d, tx_bit_d, rx_bit_d};
            {tx_sh_q, rx_sh_q, tx_par_q, rx_pok_q} <= {tx_sh_d, rx_sh_d, tx_par_d, rx_pok_d};
            txw_q <= txw_q + AW'(tx_push);
            txr_q <= txr_q + AW'(tx_pop);
            txc_q <= txc_q + CW'(tx_push) - CW'(tx_pop);
            rxw_q <= rxw_q + AW'(rx_push);
            rxr_q <= rxr_q + AW'(rx_pop);
            rxc_q <= rxc_q + CW'(rx_push) - CW'(rx_pop);
        end
    end

    assign rdata_o = addr_i == 2'd0 ? {11'd0, tx_state_q != IDLE, rx_empty, rx_full, tx_empty, tx_full,
                                       5'd0, perr_q, ferr_q, ovr_q, 2'd0, ctrl_q} :
                     addr_i == 2'd1 ? 32'(rx_head) :
                     addr_i == 2'd2 ? {16'd0, div_q} :
                                      {7'd0, 9'(rxc_q), 7'd0, 9'(txc_q)};
    assign tx_o  = tx_q;
    assign irq_o = irq_q;
endmodule
